// File: rtl/pulse_led_pkg.sv
// Shared types and helpers for the pulse-to-LED blink path.
package pulse_led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    function automatic int timer_width(input int on_c, input int off_c);
        int m;
        m = (on_c > off_c) ? on_c : off_c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down event counter; a dec at zero is ignored.
module sat_updown_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         full,
    output logic         drop
);

    logic dec_ok;

    assign dec_ok = dec && (value != '0);
    assign full   = &value;
    assign drop   = inc && !dec_ok && full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (inc && !dec_ok && !full) begin
            value <= value + 1'b1;
        end else if (dec_ok && !inc) begin
            value <= value - 1'b1;
        end
    end

endmodule

// File: rtl/pulse_led_blinker.sv
// Turns single-cycle event pulses into one visible LED blink each,
// queueing pulses that arrive while a blink is in progress.
module pulse_led_blinker
    import pulse_led_pkg::*;
#(
    parameter int ON_CYCLES  = 10_000_000,
    parameter int OFF_CYCLES = 10_000_000,
    parameter int PEND_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pulse,
    input  logic              clr_ovf,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int TW = timer_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

    state_t        state;
    logic [TW-1:0] timer;
    logic          at_start;
    logic          has_pend;
    logic          go;
    logic          fast;
    logic          inc;
    logic          dec;
    logic          full;
    logic          drop;

    // A new blink may start from IDLE or on the last OFF cycle.
    assign at_start = (state == ST_IDLE) ||
                      (state == ST_OFF && timer == '0);
    assign has_pend = (pending != '0);
    assign go       = at_start && (has_pend || pulse);
    assign fast     = at_start && pulse && !has_pend;
    assign inc      = pulse && !fast;
    assign dec      = at_start && has_pend;

    sat_updown_counter #(
        .W(PEND_W)
    ) u_pend (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (inc),
        .dec  (dec),
        .value(pending),
        .full (full),
        .drop (drop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            timer    <= '0;
            led      <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (drop && full) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end

            unique case (state)
                ST_IDLE: begin
                    if (go) begin
                        state <= ST_ON;
                        timer <= ON_LOAD;
                        led   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (timer == '0) begin
                        state <= ST_OFF;
                        timer <= OFF_LOAD;
                        led   <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_OFF: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (go) begin
                        state <= ST_ON;
                        timer <= ON_LOAD;
                        led   <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    timer <= '0;
                    led   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_led_blinker.sv
// Scoreboard bench for pulse_led_blinker against a blink-schedule model.
module tb_pulse_led_blinker;

    localparam int ON   = 4;
    localparam int OFF  = 3;
    localparam int PW   = 2;
    localparam int QMAX = (1 << PW) - 1;

    typedef struct {
        logic          led;
        logic          busy;
        logic [PW-1:0] pend;
        logic          ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pulse = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          led;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    int n_chk = 0;
    int n_fail = 0;

    exp_t sb[$];

    // Model: outstanding blink count plus the edge index of the last start.
    int k = 0;
    int last_s = -1000000;
    int q = 0;
    bit ovf = 1'b0;

    pulse_led_blinker #(
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .PEND_W    (PW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pulse   (pulse),
        .clr_ovf (clr_ovf),
        .led     (led),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, req, $time);
        end
    endtask

    task automatic model_step(input bit p, input bit c);
        exp_t e;
        bit   dropped;
        k++;
        dropped = 1'b0;
        if ((k - last_s) >= ON + OFF && (q > 0 || p)) begin
            last_s = k;
            if (q > 0 && !p) q--;
        end else if (p) begin
            if (q == QMAX) dropped = 1'b1;
            else q++;
        end
        if (dropped) ovf = 1'b1;
        else if (c) ovf = 1'b0;
        e.led  = (k - last_s) < ON;
        e.busy = (k - last_s) < ON + OFF;
        e.pend = PW'(q);
        e.ovf  = ovf;
        sb.push_back(e);
    endtask

    task automatic cyc(input bit p, input bit c);
        @(negedge clk);
        rst_n   = 1'b1;
        pulse   = p;
        clr_ovf = c;
        model_step(p, c);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        rst_n   = 1'b0;
        pulse   = 1'b0;
        clr_ovf = 1'b0;
        #1;
        chk("rst_led", 32'(led), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pend", 32'(pending), 0);
        chk("rst_ovf", 32'(overflow), 0);
        k++;
        q      = 0;
        ovf    = 1'b0;
        last_s = -1000000;
        e.led  = 1'b0;
        e.busy = 1'b0;
        e.pend = '0;
        e.ovf  = 1'b0;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("led", 32'(led), 32'(e.led));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("pending", 32'(pending), 32'(e.pend));
                chk("overflow", 32'(overflow), 32'(e.ovf));
            end
        end
    end

    initial begin : stim
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("init_led", 32'(led), 0);
        chk("init_busy", 32'(busy), 0);
        chk("init_pend", 32'(pending), 0);
        chk("init_ovf", 32'(overflow), 0);

        idle(9);
        cyc(1'b1, 1'b0);
        idle(12);

        repeat (3) cyc(1'b1, 1'b0);
        idle(28);

        repeat (5) cyc(1'b1, 1'b0);
        idle(35);

        cyc(1'b1, 1'b0);
        idle(6);
        cyc(1'b1, 1'b0);
        idle(12);

        repeat (3) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        do_reset();
        idle(15);

        repeat (4) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        idle(35);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 19) == 0) begin
                repeat ($urandom_range(2, 6)) cyc(1'b1, 1'b0);
            end else begin
                cyc($urandom_range(0, 5) == 0,
                    $urandom_range(0, 15) == 0);
            end
        end
        idle(60);

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_led_blinker.md
Name: pulse_led_blinker

Overview:
- Output-side counterpart of the debounced button path: converts single-cycle event pulses back into human-visible LED blinks.
- Each accepted pulse produces exactly one blink: LED on for ON_CYCLES, then off for OFF_CYCLES.
- Pulses arriving while a blink is in progress are queued in a saturating pending counter, so bursts are never merged into one blink.
- Sits between edge-detected button/event pulses and the board LED pins.

Parameters:
- ON_CYCLES, 10_000_000, LED-high duration per blink in clk cycles (100 ms at 100 MHz); must be >= 1.
- OFF_CYCLES, 10_000_000, mandatory LED-low gap after each blink in clk cycles; must be >= 1.
- PEND_W, 4, width of the pending counter; max queued blinks = 2^PEND_W-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous reset, active low.
- pulse  input  1  single-cycle event request, synchronous to clk.
- clr_ovf  input  1  synchronous clear of the overflow flag.
- led  output  1  blink output, registered.
- busy  output  1  high while state != IDLE.
- pending  output  PEND_W  number of queued, not-yet-started blinks.
- overflow  output  1  sticky flag: at least one pulse was dropped.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, led=0, busy=0, pending=0, overflow=0, timer=0. Reset mid-blink forces led low immediately, with no completion of the blink.
- Timer width = $clog2(max(ON_CYCLES,OFF_CYCLES)+1).
- All outputs are registered.
- FSM states: IDLE, ON, OFF.
- IDLE:
  - If pending!=0 or pulse=1, go to ON, load timer=ON_CYCLES-1, set led=1.
  - The fast path consumes the pulse directly; pending does not increment.
  - If pending!=0 and pulse=1, decrement pending by one and increment it by one, so pending is unchanged.
  - led rises at the same edge that samples the pulse, giving 1-cycle latency.
- ON:
  - led=1. Timer decrements each cycle.
  - At timer==0, go to OFF, load timer=OFF_CYCLES-1, set led=0.
  - led is high for exactly ON_CYCLES cycles.
- OFF:
  - led=0. Timer decrements each cycle.
  - At timer==0: if (pending!=0 or pulse=1), go to ON directly, with no IDLE cycle, using the same consume rules as IDLE.
  - Otherwise go to IDLE.
- Pending counter, per edge:
  - inc = pulse and not consumed-by-fast-path.
  - dec = a blink starts from queue (pending!=0 at a start point).
  - inc and dec in the same cycle leave pending unchanged.
  - inc with pending==2^PEND_W-1 and no dec: pulse dropped, pending holds, overflow<=1.
- overflow: set has priority over clr_ovf in the same cycle. Otherwise clr_ovf=1 clears it. Reset clears it.
- busy = (state != IDLE), registered alongside state.
- Invariant: number of blinks emitted = number of pulses accepted (pulses minus drops).

Decomposition:
- Shared package pulse_led_pkg holds the state encoding constants (ST_IDLE, ST_ON, ST_OFF; 2-bit) and a clog2-based width helper.
- One natural sub-module: sat_updown_counter (width PEND_W; inc/dec inputs; outputs value, full, and a drop strobe). It is reusable for other event queues in the design.
- FSM and timer remain in the top module.

Test Plan (ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2):
- Single pulse at cycle 10 -> led=1 during cycles 11-14, led=0 during 15-17, busy=1 during 11-17, IDLE from 18; pending stays 0.
- 3 pulses on cycles 10, 11, 12 -> pending goes 0, 1, 2, then decrements at each blink start; exactly 3 blinks, each led high for 4 cycles and separated by 3 low cycles; overflow=0.
- 5 pulses on cycles 10-14 -> first pulse blinks immediately, pending saturates at 3, fifth pulse dropped, overflow=1; exactly 4 blinks total; overflow stays 1 afterwards.
- Pulse on the final OFF cycle with pending=0 -> led=1 on the next cycle, busy never drops, pending stays 0.
- rst_n low for 1 cycle in the middle of ON with pending=2 -> led, busy, pending, and overflow all read 0 immediately; no further blinks occur.
- clr_ovf=1 in the same cycle as a drop -> overflow stays 1; clr_ovf=1 in the next cycle with no drop -> overflow=0.
